// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, counter-width helper, colour expansion and
// the flag bundle carried down the display pipeline.
// Optional feature macro: VGA_TESTPAT_EN (carries the colour-bar index in the flags).
package vga_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  // Widest colour channel the expansion helper supports.
  localparam int unsigned MaxColorW = 16;

  typedef struct packed {
`ifdef VGA_TESTPAT_EN
    logic [2:0] bar;
`endif
    logic       vis;
    logic       hs;
    logic       vs;
    logic       line;
    logic       frame;
  } vga_flags_t;

  // Counter width for n states; never below one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Replicate an in_w-bit channel MSB-first into out_w bits (right-aligned result).
  function automatic logic [MaxColorW-1:0] expand_ch(input logic [MaxColorW-1:0] v,
                                                      input int in_w, input int out_w);
    logic [MaxColorW-1:0] res;
    res = '0;
    for (int i = 0; i < int'(MaxColorW); i++) begin
      if (i < out_w) begin
        res[4'(out_w - 1 - i)] = v[4'(in_w - 1 - (i % in_w))];
      end
    end
    return res;
  endfunction

  // Colour bar order: white, yellow, cyan, green, magenta, red, blue, black ({R,G,B}).
  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    logic [2:0] rgb;
    case (bar)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// vga_scan_counter: x/y raster counters with clock enable and wrap, plus the registered
// stage-0 decode (request address and region flags) for the current position.
// Optional feature macro: VGA_TESTPAT_EN (adds the colour-bar index output).
module vga_scan_counter import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic                         en,
  output logic                         req,
  output logic [cnt_w(H_ACTIVE)-1:0]   h_addr,
  output logic [cnt_w(V_ACTIVE)-1:0]   v_addr,
`ifdef VGA_TESTPAT_EN
  output logic [2:0]                   bar,
`endif
  output logic                         vis,
  output logic                         hs,
  output logic                         vs,
  output logic                         line,
  output logic                         frame
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW  = cnt_w(H_TOTAL);
  localparam int unsigned YW  = cnt_w(V_TOTAL);
  localparam int unsigned HAW = cnt_w(H_ACTIVE);
  localparam int unsigned VAW = cnt_w(V_ACTIVE);

  // Bounds use one extra bit so an end bound equal to the total still fits.
  typedef logic [XW:0] xe_t;
  typedef logic [YW:0] ye_t;
  localparam xe_t XLast  = xe_t'(H_TOTAL - 1);
  localparam xe_t XAct   = xe_t'(H_ACTIVE);
  localparam xe_t XSync0 = xe_t'(H_ACTIVE + H_FP);
  localparam xe_t XSync1 = xe_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam ye_t YLast  = ye_t'(V_TOTAL - 1);
  localparam ye_t YAct   = ye_t'(V_ACTIVE);
  localparam ye_t YSync0 = ye_t'(V_ACTIVE + V_FP);
  localparam ye_t YSync1 = ye_t'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  xe_t           xe;
  ye_t           ye;
  logic          vis_d, hs_d, vs_d;

  assign xe    = {1'b0, x_q};
  assign ye    = {1'b0, y_q};
  assign vis_d = (xe < XAct) && (ye < YAct);
  assign hs_d  = (xe >= XSync0) && (xe < XSync1);
  assign vs_d  = (ye >= YSync0) && (ye < YSync1);

`ifdef VGA_TESTPAT_EN
  localparam int unsigned BarW = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
  logic [XW-1:0] bar_raw;
  logic [2:0]    bar_d;
  assign bar_raw = x_q / XW'(BarW);
  assign bar_d   = (bar_raw > XW'(7)) ? 3'd7 : bar_raw[2:0];
`endif

  // Next raster position: x wraps at the line end, y steps only on that wrap.
  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (xe == XLast) begin
      x_d = '0;
      y_d = (ye == YLast) ? '0 : y_q + 1'b1;
    end
  end

  // Counters and stage-0 registers; everything holds while en is low.
  always_ff @(posedge pclk) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      req    <= 1'b0;
      h_addr <= '0;
      v_addr <= '0;
      vis    <= 1'b0;
      hs     <= 1'b0;
      vs     <= 1'b0;
      line   <= 1'b0;
      frame  <= 1'b0;
`ifdef VGA_TESTPAT_EN
      bar    <= '0;
`endif
    end else if (en) begin
      x_q    <= x_d;
      y_q    <= y_d;
      req    <= vis_d;
      h_addr <= vis_d ? x_q[HAW-1:0] : '0;
      v_addr <= vis_d ? y_q[VAW-1:0] : '0;
      vis    <= vis_d;
      hs     <= hs_d;
      vs     <= vs_d;
      line   <= vis_d && (x_q == '0);
      frame  <= (x_q == '0) && (y_q == '0);
`ifdef VGA_TESTPAT_EN
      bar    <= bar_d;
`endif
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster scan with look-ahead pixel requests, a flag
// delay line matching the upstream read latency, colour expansion and registered outputs.
// Optional feature macro: VGA_TESTPAT_EN (adds test_mode input selecting colour bars).
module vga_timing_gen import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned IN_CH_W  = 4,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic                       en,
`ifdef VGA_TESTPAT_EN
  input  logic                       test_mode,
`endif
  input  logic [3*IN_CH_W-1:0]       vga_data,
  output logic                       req,
  output logic [cnt_w(H_ACTIVE)-1:0] h_addr,
  output logic [cnt_w(V_ACTIVE)-1:0] v_addr,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       valid,
  output logic [COLOR_W-1:0]         vga_r,
  output logic [COLOR_W-1:0]         vga_g,
  output logic [COLOR_W-1:0]         vga_b,
  output logic                       line_start,
  output logic                       frame_start
);

  logic       s0_vis, s0_hs, s0_vs, s0_line, s0_frame;
`ifdef VGA_TESTPAT_EN
  logic [2:0] s0_bar;
`endif
  vga_flags_t s0;
  vga_flags_t flags_dly;

  vga_scan_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_scan (
    .pclk   (pclk),
    .reset  (reset),
    .en     (en),
    .req    (req),
    .h_addr (h_addr),
    .v_addr (v_addr),
`ifdef VGA_TESTPAT_EN
    .bar    (s0_bar),
`endif
    .vis    (s0_vis),
    .hs     (s0_hs),
    .vs     (s0_vs),
    .line   (s0_line),
    .frame  (s0_frame)
  );

  // Bundle the stage-0 flags for the delay line.
  always_comb begin
    s0       = '0;
    s0.vis   = s0_vis;
    s0.hs    = s0_hs;
    s0.vs    = s0_vs;
    s0.line  = s0_line;
    s0.frame = s0_frame;
`ifdef VGA_TESTPAT_EN
    s0.bar   = s0_bar;
`endif
  end

  if (RD_LAT == 0) begin : g_no_lat
    assign flags_dly = s0;
  end else begin : g_lat
    vga_flags_t dly_q [RD_LAT];

    // Hold the flags back until the matching pixel data arrives from upstream.
    always_ff @(posedge pclk) begin
      if (!reset) begin
        for (int i = 0; i < int'(RD_LAT); i++) dly_q[i] <= '0;
      end else if (en) begin
        dly_q[0] <= s0;
        for (int i = 1; i < int'(RD_LAT); i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign flags_dly = dly_q[RD_LAT-1];
  end

  logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;
`ifdef VGA_TESTPAT_EN
  logic [2:0]         bar_c;
`endif

  // Expanded colour for the pixel whose data is on vga_data this cycle.
  always_comb begin
    r_nxt = COLOR_W'(expand_ch(MaxColorW'(vga_data[3*IN_CH_W-1 -: IN_CH_W]), IN_CH_W, COLOR_W));
    g_nxt = COLOR_W'(expand_ch(MaxColorW'(vga_data[2*IN_CH_W-1 -: IN_CH_W]), IN_CH_W, COLOR_W));
    b_nxt = COLOR_W'(expand_ch(MaxColorW'(vga_data[IN_CH_W-1:0]), IN_CH_W, COLOR_W));
`ifdef VGA_TESTPAT_EN
    bar_c = bar_rgb(flags_dly.bar);
    if (test_mode) begin
      r_nxt = {COLOR_W{bar_c[2]}};
      g_nxt = {COLOR_W{bar_c[1]}};
      b_nxt = {COLOR_W{bar_c[0]}};
    end
`endif
  end

  // Output stage: sync, blank and colour registered together so they stay aligned.
  always_ff @(posedge pclk) begin
    if (!reset) begin
      valid       <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (en) begin
      valid       <= flags_dly.vis;
      hsync       <= flags_dly.hs ? HS_POL : ~HS_POL;
      vsync       <= flags_dly.vs ? VS_POL : ~VS_POL;
      line_start  <= flags_dly.line;
      frame_start <= flags_dly.frame;
      vga_r       <= flags_dly.vis ? r_nxt : '0;
      vga_g       <= flags_dly.vis ? g_nxt : '0;
      vga_b       <= flags_dly.vis ? b_nxt : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-raster bench. A driver issues reset/enable stimulus and pushes
// the expected display record of each requested pixel; a monitor pops and compares.
module tb_vga_timing_gen;

  localparam int unsigned HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int unsigned VA = 8, VFP = 1, VSW = 2, VBP = 2;
  localparam int unsigned HT = HA + HFP + HSW + HBP;
  localparam int unsigned VT = VA + VFP + VSW + VBP;
  localparam int unsigned FT = HT * VT;
  localparam logic HSP = 1'b0, VSP = 1'b1;
  localparam int unsigned LAT = 2;

  logic       pclk = 1'b0, reset = 1'b0, en = 1'b0;
  logic [11:0] vga_data = '0;
  logic       req, hsync, vsync, valid, line_start, frame_start;
  logic [3:0] h_addr;
  logic [2:0] v_addr;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HS_POL (HSP), .VS_POL (VSP), .IN_CH_W (4), .COLOR_W (8), .RD_LAT (LAT)
  ) dut (
    .pclk (pclk), .reset (reset), .en (en), .vga_data (vga_data),
    .req (req), .h_addr (h_addr), .v_addr (v_addr),
    .hsync (hsync), .vsync (vsync), .valid (valid),
    .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
    .line_start (line_start), .frame_start (frame_start)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic valid, hsync, vsync, line, frame;
    logic [7:0] r, g, b;
  } disp_t;
  typedef struct packed {logic req; logic [3:0] h; logic [2:0] v;} rq_t;

  logic [11:0] mem [VA][HA];
  disp_t exp_q[$];
  int unsigned cnt;
  int errors = 0, checks = 0;

  // Replication equals scaling by (2^8-1)/(2^4-1).
  function automatic logic [7:0] widen(input logic [3:0] c);
    return 8'((int'(c) * 255) / 15);
  endfunction

  function automatic disp_t disp_reset();
    disp_t d;
    d = '0;
    d.hsync = ~HSP;
    d.vsync = ~VSP;
    return d;
  endfunction

  function automatic disp_t disp_model(input int unsigned pix);
    int unsigned x, y;
    logic vis;
    logic [11:0] w;
    disp_t d;
    x = (pix % FT) % HT;
    y = (pix % FT) / HT;
    vis = (x < HA) && (y < VA);
    w = vis ? mem[3'(y)][4'(x)] : 12'h0;
    d.valid = vis;
    d.hsync = (x >= HA + HFP && x < HA + HFP + HSW) ? HSP : ~HSP;
    d.vsync = (y >= VA + VFP && y < VA + VFP + VSW) ? VSP : ~VSP;
    d.line  = vis && (x == 0);
    d.frame = (x == 0) && (y == 0);
    d.r = vis ? widen(w[11:8]) : 8'h0;
    d.g = vis ? widen(w[7:4]) : 8'h0;
    d.b = vis ? widen(w[3:0]) : 8'h0;
    return d;
  endfunction

  function automatic rq_t rq_model(input int unsigned pix);
    int unsigned x, y;
    rq_t r;
    x = (pix % FT) % HT;
    y = (pix % FT) / HT;
    r.req = (x < HA) && (y < VA);
    r.h = r.req ? 4'(x) : 4'h0;
    r.v = r.req ? 3'(y) : 3'h0;
    return r;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Issue one cycle of stimulus; each enabled request pushes its expected display record.
  task automatic step(input logic r, input logic e);
    @(negedge pclk);
    reset = r;
    en = e;
    if (!r) cnt = 0;
    else if (e) begin
      exp_q.push_back(disp_model(cnt));
      cnt = (cnt + 1) % FT;
    end
  endtask

  // Upstream frame source: returns the stored word RD_LAT enabled cycles after a request.
  initial begin : upstream
    logic [11:0] pipe [LAT+1];
    logic rs, es;
    for (int i = 0; i <= int'(LAT); i++) pipe[i] = '0;
    forever begin
      @(posedge pclk);
      rs = reset;
      es = en;
      #1;
      if (!rs) begin
        for (int i = 0; i <= int'(LAT); i++) pipe[i] = '0;
        vga_data = 12'($urandom);
      end else if (es) begin
        for (int i = int'(LAT); i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = req ? mem[v_addr][h_addr] : 12'($urandom);
        vga_data = pipe[LAT];
      end
    end
  end

  // Monitor: request outputs against the raster model, display outputs against the queue.
  initial begin : monitor
    int unsigned k;
    disp_t last, act;
    rq_t rq_exp, rq_act;
    logic rs, es;
    k = 0;
    last = disp_reset();
    rq_exp = '0;
    forever begin
      @(posedge pclk);
      rs = reset;
      es = en;
      #1;
      if (!rs) begin
        k = 0;
        exp_q.delete();
        last = disp_reset();
        rq_exp = '0;
      end else if (es) begin
        k++;
        rq_exp = rq_model(k - 1);
        if (exp_q.size() >= int'(LAT + 2)) last = exp_q.pop_front();
        else last = disp_reset();
      end
      rq_act = {req, h_addr, v_addr};
      act = {valid, hsync, vsync, line_start, frame_start, vga_r, vga_g, vga_b};
      checks += 2;
      if (rq_act !== rq_exp) begin
        errors++;
        $display("FAIL req t=%0t got=%h want=%h", $time, rq_act, rq_exp);
      end
      if (act !== last) begin
        errors++;
        $display("FAIL disp t=%0t got=%h want=%h", $time, act, last);
      end
    end
  end

  initial begin : driver
    int first, second, vs_cnt, hs_cnt, e1, e2;
    for (int y = 0; y < int'(VA); y++)
      for (int x = 0; x < int'(HA); x++) mem[y][x] = 12'($urandom);
    mem[0][0] = 12'hA3F;
    mem[0][1] = 12'h000;
    mem[0][2] = 12'hFFF;
    cnt = 0;

    repeat (3) step(1'b0, 1'($urandom));

    // Continuous run: frame period and sync durations.
    first = -1; second = -1; vs_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < int'(3 * FT) && second < 0; i++) begin
      step(1'b1, 1'b1);
      if (frame_start) begin
        if (first < 0) first = i;
        else second = i;
      end
      if (first >= 0 && second < 0) begin
        if (vsync == VSP) vs_cnt++;
        if (hsync == HSP) hs_cnt++;
      end
    end
    chk("frame_period", second - first, FT);
    chk("vsync_len", vs_cnt, VSW * HT);
    chk("hsync_len", hs_cnt, HSW * VT);

    // Stall for 10 cycles mid-line in the visible area.
    for (int i = 0; i < int'(2 * FT) && !((cnt % HT) == 9 && (cnt / HT) == 3); i++)
      step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    repeat (HT) step(1'b1, 1'b1);

    // Reset mid-frame, then time the frame_start pulses from the first request.
    for (int i = 0; i < int'(2 * FT) && cnt != 5 * HT + 10; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    e1 = -1; e2 = -1;
    for (int i = 1; i < int'(2 * FT + 10) && e2 < 0; i++) begin
      step(1'b1, 1'b1);
      if (frame_start) begin
        if (e1 < 0) e1 = i - 1;
        else e2 = i - 1;
      end
    end
    chk("first_frame_start", e1 - 1, LAT + 1);
    chk("next_frame_start", e2 - 1, FT + LAT + 1);

    // Random enables and occasional resets.
    for (int i = 0; i < 2500; i++)
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 5) != 0));

    repeat (LAT + 4) step(1'b1, 1'b1);
    @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
